// File: rtl/beep_pkg.sv
// Shared types and constants for the beep scheduler: FSM state encoding,
// the per-requester beep pattern record and its constant table, and the
// priority pick helper. Optional feature macro used by the top: BEEP_PREEMPT_EN.
package beep_pkg;

  localparam int NREQ = 4;
  localparam int CW   = 10;
  localparam int HW   = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TONE = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic [HW-1:0] half;
    logic [1:0]    nbeep;
    logic [CW-1:0] on;
    logic [CW-1:0] gap;
  } pat_t;

  // Index 0 start, 1 hit, 2 miss, 3 game over
  localparam pat_t [NREQ-1:0] PAT_TAB = {
    pat_t'{half: 2'd1, nbeep: 2'd1, on: 10'd1000, gap: 10'd0},
    pat_t'{half: 2'd2, nbeep: 2'd3, on: 10'd150,  gap: 10'd50},
    pat_t'{half: 2'd2, nbeep: 2'd2, on: 10'd100,  gap: 10'd100},
    pat_t'{half: 2'd1, nbeep: 2'd1, on: 10'd200,  gap: 10'd0}
  };

  // Highest set index wins; returns 0 for an empty vector
  function automatic logic [1:0] hi_idx(input logic [NREQ-1:0] v);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (v[i]) r = 2'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/beep_sched_if.sv
// Game-logic <-> beep scheduler bundle: request pulses and mute in,
// buzzer drive and status out.
interface beep_sched_if;
  import beep_pkg::*;

  logic [NREQ-1:0] req;
  logic            mute;
  logic            beep;
  logic            busy;
  logic [1:0]      grant;
  logic            over;

  modport master (output req, mute, input beep, busy, grant, over);
  modport slave  (input req, mute, output beep, busy, grant, over);

endinterface

// File: rtl/beep_tone_gen.sv
// Square-wave divider: output toggles every half_i enabled cycles.
// clr_i restarts the wave at phase 0. tone_d_o exposes the next value so
// the owner can register a derived output aligned with the phase register.
module beep_tone_gen
  import beep_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [HW-1:0] half_i,
  output logic          tone_d_o
);

  logic          phase_q, phase_d;
  logic [HW-1:0] cnt_q, cnt_d;

  // Next phase/count: restart on clear, toggle when the half period expires
  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    if (clr_i) begin
      phase_d = 1'b0;
      cnt_d   = '0;
    end else if (en_i) begin
      if (cnt_q == half_i - HW'(1)) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + HW'(1);
      end
    end
  end

  // Divider state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
    end
  end

  assign tone_d_o = phase_d;

endmodule

// File: rtl/beep_sched.sv
// Beep scheduler top: latches request pulses, serves the highest pending
// requester, and plays its pattern (tone bursts and gaps) on the buzzer.
// Optional macro BEEP_PREEMPT_EN: a higher pending request aborts the
// running pattern (no over pulse) and is granted from IDLE.
module beep_sched
  import beep_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  beep_sched_if.slave  bus
);

  state_e          state_q, state_d;
  logic [1:0]      grant_q, grant_d;
  logic [NREQ-1:0] pend_q, pend_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      nb_q, nb_d;
  logic            beep_q, beep_d;
  logic [NREQ-1:0] clr_mask;
  logic            tone_clr;
  logic            tone_d;
  logic [1:0]      pick;
  pat_t            pat;

  assign pat  = PAT_TAB[grant_q];
  assign pick = hi_idx(pend_q);

  beep_tone_gen u_tone (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (tone_clr),
    .en_i     (state_q == ST_TONE),
    .half_i   (pat.half),
    .tone_d_o (tone_d)
  );

  // Pattern sequencer: next state, counters, grant and pending clear
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    cnt_d    = cnt_q;
    nb_d     = nb_q;
    clr_mask = '0;
    tone_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|pend_q) begin
          grant_d        = pick;
          clr_mask[pick] = 1'b1;
          state_d        = ST_TONE;
          cnt_d          = '0;
          nb_d           = '0;
          tone_clr       = 1'b1;
        end
      end
      ST_TONE: begin
        if (cnt_q == pat.on - CW'(1)) begin
          cnt_d = '0;
          if (nb_q != pat.nbeep - 2'd1) begin
            if (pat.gap != '0) begin
              state_d = ST_GAP;
            end else begin
              nb_d     = nb_q + 2'd1;
              tone_clr = 1'b1;
            end
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == pat.gap - CW'(1)) begin
          cnt_d    = '0;
          nb_d     = nb_q + 2'd1;
          state_d  = ST_TONE;
          tone_clr = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
`ifdef BEEP_PREEMPT_EN
    if ((state_q == ST_TONE || state_q == ST_GAP) && (|pend_q) && (pick > grant_q)) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      nb_d     = '0;
      tone_clr = 1'b0;
    end
`endif
  end

  // New requests win over the grant clear, so a request during grant replays
  assign pend_d = (pend_q & ~clr_mask) | bus.req;

  // Buzzer drive is registered and aligned with the state it belongs to
  assign beep_d = tone_d & ~bus.mute & (state_d == ST_TONE);

  // Control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      pend_q  <= '0;
      cnt_q   <= '0;
      nb_q    <= '0;
      beep_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      nb_q    <= nb_d;
      beep_q  <= beep_d;
    end
  end

  assign bus.beep  = beep_q;
  assign bus.busy  = (state_q != ST_IDLE);
  assign bus.grant = grant_q;
  assign bus.over  = (state_q == ST_DONE);

endmodule

// File: tb/tb_beep_sched.sv
// Scoreboard bench for beep_sched: stimulus pushes expected patterns
// (grant, first TONE cycle, over/abort cycle); a negedge monitor follows
// each pattern cycle by cycle against a table model of the beep waveform.
module tb_beep_sched;
  import beep_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  beep_sched_if bus();

  beep_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int g;
    int start;
    int end_c;
    bit aborted;
  } exp_t;

  exp_t sbq[$];

  int n_cmp = 0;
  int n_err = 0;

  int T_HALF [4] = '{1, 2, 2, 1};
  int T_NB   [4] = '{1, 2, 3, 1};
  int T_ON   [4] = '{200, 100, 150, 1000};
  int T_GAP  [4] = '{0, 100, 50, 0};

  task automatic check(input string name, input int act, input int req_v);
    n_cmp++;
    if (act !== req_v) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0d, required %0d", name, cyc, act, req_v);
    end
  endtask

  // ---------------- monitor ----------------
  bit   m_active = 1'b0;
  int   m_g, m_st, m_berr;
  logic m_prev_mute = 1'b0;

  always @(negedge clk) begin
    int   k, span, r, ebit;
    exp_t e;
    if (!m_active && bus.busy) begin
      if (sbq.size() == 0) begin
        check("unexpected_start", 1, 0);
      end else begin
        check("start_cycle", cyc, sbq[0].start);
        check("start_grant", int'(bus.grant), sbq[0].g);
        m_active = 1'b1;
        m_g      = int'(bus.grant);
        m_st     = cyc;
        m_berr   = 0;
      end
    end else if (!m_active && bus.over) begin
      check("stray_over", 1, 0);
    end
    if (m_active) begin
      k    = cyc - m_st;
      span = T_NB[m_g] * T_ON[m_g] + (T_NB[m_g] - 1) * T_GAP[m_g];
      if (!bus.busy) begin
        e = sbq.pop_front();
        check("abort_expected", int'(e.aborted), 1);
        check("abort_cycle", cyc, e.end_c);
        m_active = 1'b0;
      end else if (k >= span) begin
        e = sbq.pop_front();
        check("over_pulse", int'(bus.over), 1);
        check("over_cycle", cyc, e.end_c);
        check("over_not_aborted", int'(e.aborted), 0);
        check("done_beep_low", int'(bus.beep), 0);
        check("beep_wave_errs", m_berr, 0);
        m_active = 1'b0;
      end else begin
        r    = k % (T_ON[m_g] + T_GAP[m_g]);
        ebit = (r < T_ON[m_g]) ? ((r / T_HALF[m_g]) % 2) : 0;
        if (m_prev_mute) ebit = 0;
        if (int'(bus.beep) != ebit) m_berr++;
        if (bus.over) m_berr++;
        if (int'(bus.grant) != m_g) m_berr++;
      end
    end
    m_prev_mute = bus.mute;
  end

  // ---------------- stimulus ----------------
  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic [3:0] v, input int n);
    wait_cyc(n);
    bus.req = bus.req | v;
    wait_cyc(n + 1);
    bus.req = bus.req & ~v;
  endtask

  initial begin
    bus.req  = '0;
    bus.mute = 1'b0;
    rst      = 1'b1;

    wait_cyc(2);
    @(negedge clk);
    check("rst_beep",  int'(bus.beep),  0);
    check("rst_busy",  int'(bus.busy),  0);
    check("rst_over",  int'(bus.over),  0);
    check("rst_grant", int'(bus.grant), 0);
    wait_cyc(3);
    rst = 1'b0;

    // start
    sbq.push_back('{0, 12, 212, 1'b0});
    pulse(4'b0001, 10);

    // hit
    sbq.push_back('{1, 302, 602, 1'b0});
    pulse(4'b0010, 300);

    // miss and start together: miss first, start 2 cycles after its over
    sbq.push_back('{2, 702, 1252, 1'b0});
    sbq.push_back('{0, 1254, 1454, 1'b0});
    pulse(4'b0101, 700);

    // game over re-requested during its own playback: one replay
    sbq.push_back('{3, 1502, 2502, 1'b0});
    sbq.push_back('{3, 2504, 3504, 1'b0});
    pulse(4'b1000, 1500);
    pulse(4'b1000, 1600);
    pulse(4'b1000, 1800);
    pulse(4'b1000, 2000);

    // reset at cycle 50 of a hit tone, with start pending
    sbq.push_back('{1, 3602, 3652, 1'b1});
    pulse(4'b0010, 3600);
    pulse(4'b0001, 3620);
    wait_cyc(3651);
    rst = 1'b1;
    wait_cyc(3652);
    @(negedge clk);
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_beep", int'(bus.beep), 0);
    check("midrst_over", int'(bus.over), 0);
    wait_cyc(3653);
    rst = 1'b0;
    wait_cyc(3800);

    // hit then game over arriving mid-hit; mute during game over
`ifdef BEEP_PREEMPT_EN
    sbq.push_back('{1, 3902, 3932, 1'b1});
    sbq.push_back('{3, 3933, 4933, 1'b0});
`else
    sbq.push_back('{1, 3902, 4202, 1'b0});
    sbq.push_back('{3, 4204, 5204, 1'b0});
`endif
    pulse(4'b0010, 3900);
    pulse(4'b1000, 3930);
    wait_cyc(4300);
    bus.mute = 1'b1;
    wait_cyc(4400);
    bus.mute = 1'b0;

    wait_cyc(5300);
    check("queue_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
